pc_sequencer: RTL and testbench

Fetch-side program-counter controller for the RISC-V core. Owns the fetch PC register and chooses each cycle between sequential advance (+2 for compressed, +4 otherwise), hold (hazard stall or instruction-memory wait), branch redirect and trap redirect. After every redirect it drives a multi-cycle pipeline flush and masks shadow branch resolutions. It sits between the hazard unit/execute stage and instruction memory, upstream of the fetch/decode PC pipeline registers.

---
 rtl/pc_sequencer.sv | 124 ++++++++++++
 tb/tb_pc_sequencer.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Fetch PC controller: sequential advance, hold, branch/trap redirect with multi-cycle flush; PC_SEQ_COMPRESSED_EN enables +2 fetch.
// Latency: redirect at edge N drives new pcf_o, redirect_o and flush_o in cycle N+1; pc_plus_o is combinational.
// Backpressure: stall_i or !imem_ready_i holds the PC in RUN; only !imem_ready_i holds it during a flush.
module pc_sequencer #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100,
    parameter int          FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall_i,
    input  logic        imem_ready_i,
    input  logic        compressed_i,
    input  logic        branch_taken_i,
    input  logic [31:0] branch_target_i,
    input  logic        trap_i,
    output logic [31:0] pcf_o,
    output logic [31:0] pc_plus_o,
    output logic        fetch_valid_o,
    output logic        flush_o,
    output logic        redirect_o,
    output logic [1:0]  state_o
);

    typedef enum logic [1:0] {
        BOOT     = 2'b00,
        RUN      = 2'b01,
        REDIRECT = 2'b10
    } state_t;

    localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES);

    state_t      state, state_nxt;
    logic [31:0] pcf, pcf_nxt;
    logic [3:0]  flush_cnt, flush_cnt_nxt;
    logic        redirect, redirect_nxt;
    logic [31:0] pc_inc;
    logic [31:0] target_aligned;

`ifdef PC_SEQ_COMPRESSED_EN
    logic unused_target_lsb;
    assign unused_target_lsb = branch_target_i[0];
    assign pc_inc            = compressed_i ? 32'd2 : 32'd4;
    assign target_aligned    = {branch_target_i[31:1], 1'b0};
`else
    logic unused_compressed;
    assign unused_compressed = compressed_i ^ branch_target_i[1] ^ branch_target_i[0];
    assign pc_inc            = 32'd4;
    assign target_aligned    = {branch_target_i[31:2], 2'b00};
`endif

    // Plain 32-bit add: wraps from the top of the address space to zero.
    assign pc_plus_o = pcf + pc_inc;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= BOOT;
            pcf       <= RESET_PC;
            flush_cnt <= 4'd0;
            redirect  <= 1'b0;
        end else begin
            state     <= state_nxt;
            pcf       <= pcf_nxt;
            flush_cnt <= flush_cnt_nxt;
            redirect  <= redirect_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        pcf_nxt       = pcf;
        flush_cnt_nxt = flush_cnt;
        redirect_nxt  = 1'b0;
        case (state)
            BOOT: begin
                pcf_nxt   = RESET_PC;
                state_nxt = RUN;
            end
            RUN: begin
                if (trap_i) begin
                    pcf_nxt       = TRAP_VECTOR;
                    flush_cnt_nxt = FLUSH_LOAD;
                    redirect_nxt  = 1'b1;
                    state_nxt     = REDIRECT;
                end else if (branch_taken_i) begin
                    pcf_nxt       = target_aligned;
                    flush_cnt_nxt = FLUSH_LOAD;
                    redirect_nxt  = 1'b1;
                    state_nxt     = REDIRECT;
                end else if (!stall_i && imem_ready_i) begin
                    pcf_nxt = pc_plus_o;
                end
            end
            REDIRECT: begin
                // Branches and stalls here come from squashed shadow instructions.
                if (trap_i) begin
                    pcf_nxt       = TRAP_VECTOR;
                    flush_cnt_nxt = FLUSH_LOAD;
                    redirect_nxt  = 1'b1;
                end else begin
                    if (imem_ready_i) begin
                        pcf_nxt = pc_plus_o;
                    end
                    flush_cnt_nxt = flush_cnt - 4'd1;
                    if (flush_cnt <= 4'd1) begin
                        flush_cnt_nxt = 4'd0;
                        state_nxt     = RUN;
                    end
                end
            end
            default: begin
                state_nxt = BOOT;
                pcf_nxt   = RESET_PC;
            end
        endcase
    end

    assign pcf_o         = pcf;
    assign fetch_valid_o = (state == RUN) || (state == REDIRECT);
    assign flush_o       = (state == REDIRECT);
    assign redirect_o    = redirect;
    assign state_o       = state;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed-vector bench for pc_sequencer with hand-computed expected PCs and flags.
module tb_pc_sequencer;

    logic        clk;
    logic        reset;
    logic        stall_i;
    logic        imem_ready_i;
    logic        compressed_i;
    logic        branch_taken_i;
    logic [31:0] branch_target_i;
    logic        trap_i;
    logic [31:0] pcf_o;
    logic [31:0] pc_plus_o;
    logic        fetch_valid_o;
    logic        flush_o;
    logic        redirect_o;
    logic [1:0]  state_o;

    int checks = 0;
    int errors = 0;

    pc_sequencer dut (
        .clk             (clk),
        .reset           (reset),
        .stall_i         (stall_i),
        .imem_ready_i    (imem_ready_i),
        .compressed_i    (compressed_i),
        .branch_taken_i  (branch_taken_i),
        .branch_target_i (branch_target_i),
        .trap_i          (trap_i),
        .pcf_o           (pcf_o),
        .pc_plus_o       (pc_plus_o),
        .fetch_valid_o   (fetch_valid_o),
        .flush_o         (flush_o),
        .redirect_o      (redirect_o),
        .state_o         (state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_cycle(input string tag, input logic [31:0] pc, input logic [1:0] st,
                             input logic fl, input logic rd);
        chk({tag, ".pc"}, pcf_o, pc);
        chk({tag, ".state"}, {30'd0, state_o}, {30'd0, st});
        chk({tag, ".flush"}, {31'd0, flush_o}, {31'd0, fl});
        chk({tag, ".redir"}, {31'd0, redirect_o}, {31'd0, rd});
    endtask

    initial begin
        reset = 1'b1; stall_i = 1'b0; imem_ready_i = 1'b1; compressed_i = 1'b0;
        branch_taken_i = 1'b0; branch_target_i = 32'h0; trap_i = 1'b0;
        step(); step();
        // Reset state / BOOT cycle
        chk_cycle("reset", 32'h0, 2'b00, 1'b0, 1'b0);
        chk("reset.fv", {31'd0, fetch_valid_o}, 32'd0);
        reset = 1'b0;
        step(); chk_cycle("run0", 32'h0, 2'b01, 1'b0, 1'b0);
        chk("run0.fv", {31'd0, fetch_valid_o}, 32'd1);
        chk("run0.plus", pc_plus_o, 32'h4);
        step(); chk("seq4", pcf_o, 32'h4);
        step(); chk("seq8", pcf_o, 32'h8);

        // Branch at pcf=8 -> 200, shadow branch during flush ignored
        branch_taken_i = 1'b1; branch_target_i = 32'h200;
        step(); chk_cycle("br", 32'h200, 2'b10, 1'b1, 1'b1);
        chk("br.fv", {31'd0, fetch_valid_o}, 32'd1);
        branch_target_i = 32'h300;
        step(); chk_cycle("br.f2", 32'h204, 2'b10, 1'b1, 1'b0);
        branch_taken_i = 1'b0;
        step(); chk_cycle("br.end", 32'h208, 2'b01, 1'b0, 1'b0);

        // Trap and branch together -> trap wins; trap during flush restarts count
        trap_i = 1'b1; branch_taken_i = 1'b1; branch_target_i = 32'h500;
        step(); chk_cycle("trap", 32'h100, 2'b10, 1'b1, 1'b1);
        trap_i = 1'b0; branch_taken_i = 1'b0;
        step(); chk_cycle("trap.f2", 32'h104, 2'b10, 1'b1, 1'b0);
        trap_i = 1'b1;
        step(); chk_cycle("trap2", 32'h100, 2'b10, 1'b1, 1'b1);
        trap_i = 1'b0;
        step(); chk_cycle("trap2.f2", 32'h104, 2'b10, 1'b1, 1'b0);
        step(); chk_cycle("trap2.end", 32'h108, 2'b01, 1'b0, 1'b0);

        // Reach pcf=10 via branch to 8
        branch_taken_i = 1'b1; branch_target_i = 32'h8;
        step(); chk("to8", pcf_o, 32'h8);
        branch_taken_i = 1'b0;
        step(); chk("to8.c", pcf_o, 32'hC);
        step(); chk_cycle("at10", 32'h10, 2'b01, 1'b0, 1'b0);

        // Stall 3 cycles then imem wait 2 cycles
        stall_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(); chk("stall", pcf_o, 32'h10);
        end
        stall_i = 1'b0; imem_ready_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step(); chk("imem_wait", pcf_o, 32'h10);
        end
        imem_ready_i = 1'b1;
        step(); chk("resume", pcf_o, 32'h14);

        // Target alignment
        branch_taken_i = 1'b1; branch_target_i = 32'h203;
`ifdef PC_SEQ_COMPRESSED_EN
        step(); chk("align", pcf_o, 32'h202);
`else
        step(); chk("align", pcf_o, 32'h200);
`endif
        branch_taken_i = 1'b0;
        step(); step();

        // Wrap at top of address space; compressed_i ignored in default build
        branch_taken_i = 1'b1; branch_target_i = 32'hFFFF_FFF8;
        step(); chk("wrap.f8", pcf_o, 32'hFFFF_FFF8);
        branch_taken_i = 1'b0;
        step(); chk("wrap.fc", pcf_o, 32'hFFFF_FFFC);
        chk("wrap.plus", pc_plus_o, 32'h0);
        step(); chk_cycle("wrap.0", 32'h0, 2'b01, 1'b0, 1'b0);
        compressed_i = 1'b1;
        #1;
`ifdef PC_SEQ_COMPRESSED_EN
        chk("cmp.plus", pc_plus_o, 32'h2);
`else
        chk("cmp.plus", pc_plus_o, 32'h4);
`endif
        compressed_i = 1'b0;

        // Reset during REDIRECT aborts the flush
        branch_taken_i = 1'b1; branch_target_i = 32'h40;
        step(); chk_cycle("pre_rst", 32'h40, 2'b10, 1'b1, 1'b1);
        branch_taken_i = 1'b0; reset = 1'b1;
        step(); chk_cycle("mid_rst", 32'h0, 2'b00, 1'b0, 1'b0);
        chk("mid_rst.fv", {31'd0, fetch_valid_o}, 32'd0);
        reset = 1'b0;
        step(); chk_cycle("post_rst", 32'h0, 2'b01, 1'b0, 1'b0);

        // Compressed sequence 1,1,0 from pcf=0
        compressed_i = 1'b1;
`ifdef PC_SEQ_COMPRESSED_EN
        step(); chk("cseq1", pcf_o, 32'h2);
        step(); chk("cseq2", pcf_o, 32'h4);
        compressed_i = 1'b0;
        step(); chk("cseq3", pcf_o, 32'h8);
`else
        step(); chk("cseq1", pcf_o, 32'h4);
        step(); chk("cseq2", pcf_o, 32'h8);
        compressed_i = 1'b0;
        step(); chk("cseq3", pcf_o, 32'hC);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
